// File: rtl/rgb_vlc_packer.sv
// rtl/rgb_vlc_packer.sv - serial variable-length encoder for 5:5:5 RGB pixels
//
// Each channel value is coded as a 3-bit leading-one position (MSB first)
// followed by the bits below that leading one (MSB first). Channels are
// emitted R, G, B; a pixel code is 9..21 bits long.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   pix_in     pixel {R[14:10], G[9:5], B[4:0]}
//   pix_valid  pix_in holds a pixel to encode
//   pix_ready  block accepts a pixel this cycle (IDLE only)
//   bit_out    current serial code bit
//   bit_valid  bit_out is valid
//   bit_ready  downstream accepts bit_out this cycle
//   bit_last   bit_out is the final bit of the pixel
module rgb_vlc_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [14:0] pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        bit_out,
    output logic        bit_valid,
    input  logic        bit_ready,
    output logic        bit_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CNT  = 2'd1,
        MANT = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [14:0] pix_q, pix_n;
    logic [1:0]  ch, ch_n;     // 0=R, 1=G, 2=B
    logic [1:0]  idx, idx_n;   // bit position: count 2..0, mantissa 3..down

    logic [4:0]  v;
    logic [2:0]  c;
    logic [3:0]  m;
    logic        mant_end;

    // Channel currently being emitted, taken from the captured pixel only.
    always_comb begin
        case (ch)
            2'd0:    v = pix_q[14:10];
            2'd1:    v = pix_q[9:5];
            default: v = pix_q[4:0];
        endcase
    end

    // Leading-one count and left-aligned mantissa below the leading one.
    // v=0 and v=1 both give c=0 (the lowest bit is intentionally lost).
    always_comb begin
        c = 3'd0;
        m = 4'd0;
        if (v[4]) begin
            c = 3'd4;
            m = v[3:0];
        end else if (v[3]) begin
            c = 3'd3;
            m = {v[2:0], 1'b0};
        end else if (v[2]) begin
            c = 3'd2;
            m = {v[1:0], 2'b00};
        end else if (v[1]) begin
            c = 3'd1;
            m = {v[0], 3'b000};
        end
    end

    // Mantissa index counts down from 3; the c-th bit sits at index 4-c.
    assign mant_end = ({1'b0, idx} == (3'd4 - c));

    assign pix_ready = (state == IDLE) && !rst;
    assign bit_valid = (state != IDLE);

    always_comb begin
        bit_out = 1'b0;
        if (state == CNT)
            bit_out = c[idx];
        else if (state == MANT)
            bit_out = m[idx];
    end

    assign bit_last = (ch == 2'd2) &&
                      (((state == CNT) && (idx == 2'd0) && (c == 3'd0)) ||
                       ((state == MANT) && mant_end));

    always_comb begin
        state_n = state;
        pix_n   = pix_q;
        ch_n    = ch;
        idx_n   = idx;
        case (state)
            IDLE: begin
                if (pix_valid) begin
                    state_n = CNT;
                    pix_n   = pix_in;
                    ch_n    = 2'd0;
                    idx_n   = 2'd2;
                end
            end
            CNT: begin
                if (bit_ready) begin
                    if (idx != 2'd0) begin
                        idx_n = idx - 2'd1;
                    end else if (c != 3'd0) begin
                        state_n = MANT;
                        idx_n   = 2'd3;
                    end else if (ch == 2'd2) begin
                        state_n = IDLE;
                    end else begin
                        ch_n  = ch + 2'd1;
                        idx_n = 2'd2;
                    end
                end
            end
            MANT: begin
                if (bit_ready) begin
                    if (!mant_end) begin
                        idx_n = idx - 2'd1;
                    end else if (ch == 2'd2) begin
                        state_n = IDLE;
                    end else begin
                        state_n = CNT;
                        ch_n    = ch + 2'd1;
                        idx_n   = 2'd2;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pix_q <= 15'd0;
            ch    <= 2'd0;
            idx   <= 2'd0;
        end else begin
            state <= state_n;
            pix_q <= pix_n;
            ch    <= ch_n;
            idx   <= idx_n;
        end
    end

endmodule

// File: tb/tb_rgb_vlc_packer.sv
// tb/tb_rgb_vlc_packer.sv - self-checking bench for rgb_vlc_packer
module tb_rgb_vlc_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready;
    logic        bit_last;

    int total = 0;
    int bad   = 0;

    rgb_vlc_packer dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .bit_last  (bit_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference code: leading-one position of each channel as 3 bits, then the
    // bits below the leading one, most significant first.
    function automatic void build_code(input logic [14:0] p, output bit q[$]);
        int vv, cc;
        q = {};
        for (int chn = 0; chn < 3; chn++) begin
            vv = (p >> (10 - 5 * chn)) & 31;
            cc = 0;
            for (int k = 1; k <= 4; k++)
                if (vv >= (1 << k)) cc = k;
            for (int b = 2; b >= 0; b--) q.push_back(((cc >> b) & 1) != 0);
            for (int j = cc - 1; j >= 0; j--) q.push_back(((vv >> j) & 1) != 0);
        end
    endfunction

    // mode 0: bit_ready always 1; 1: random bit_ready;
    // 2: random bit_ready with pix_valid held high and pix_in changing.
    // abort_after > 0 asserts rst once that many bits have been transferred.
    task automatic send_pixel(input logic [14:0] p, input int mode, input int abort_after);
        bit q[$];
        int n, i, cyc, t;
        logic rdy, prev_stall, pbit, plast;
        build_code(p, q);
        n = q.size();
        t = 0;
        while (!pix_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("pix_ready_wait", pix_ready, 1'b1);
        pix_in    = p;
        pix_valid = 1'b1;
        @(negedge clk);
        chk("first_bit_valid", bit_valid, 1'b1);
        chk("busy_not_ready", pix_ready, 1'b0);
        if (mode != 2) pix_valid = 1'b0;
        i = 0;
        cyc = 0;
        prev_stall = 1'b0;
        pbit = 1'b0;
        plast = 1'b0;
        while (i < n && cyc < 500) begin
            if (abort_after > 0 && i == abort_after) break;
            chk("bit_valid", bit_valid, 1'b1);
            if (prev_stall) begin
                chk("stall_hold_bit", bit_out, pbit);
                chk("stall_hold_last", bit_last, plast);
            end
            if (mode == 2) begin
                chk("hold_no_ready", pix_ready, 1'b0);
                pix_in = 15'($urandom);
            end
            rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (rdy) begin
                chk("bit_out", bit_out, q[i]);
                chk("bit_last", bit_last, i == n - 1);
                i++;
            end
            prev_stall = !rdy;
            pbit = bit_out;
            plast = bit_last;
            bit_ready = rdy;
            @(negedge clk);
            cyc++;
        end
        bit_ready = 1'b1;
        pix_valid = 1'b0;
        if (abort_after > 0) begin
            chk("abort_point", i, abort_after);
            rst = 1'b1;
            #1;
            chk("rst_pix_ready", pix_ready, 1'b0);
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk("abort_bit_valid", bit_valid, 1'b0);
            chk("abort_bit_out", bit_out, 1'b0);
            chk("abort_bit_last", bit_last, 1'b0);
            chk("abort_pix_ready", pix_ready, 1'b1);
        end else begin
            chk("bit_count", i, n);
            chk("end_bit_valid", bit_valid, 1'b0);
            chk("end_pix_ready", pix_ready, 1'b1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        pix_in    = 15'd0;
        pix_valid = 1'b1;
        bit_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_pix_ready", pix_ready, 1'b0);
        chk("reset_bit_valid", bit_valid, 1'b0);
        chk("reset_bit_out", bit_out, 1'b0);
        chk("reset_bit_last", bit_last, 1'b0);
        pix_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_reset_ready", pix_ready, 1'b1);
        @(negedge clk);

        send_pixel(15'h7FFF, 0, 0);
        send_pixel(15'h0000, 0, 0);
        send_pixel(15'h0021, 0, 0);
        send_pixel({5'b00101, 5'b00001, 5'b10000}, 0, 0);
        send_pixel(15'h7FFF, 1, 0);
        send_pixel(15'h7FFF, 0, 5);
        send_pixel(15'h0000, 0, 0);
        send_pixel(15'h1234, 2, 0);
        send_pixel(15'h4A5B, 0, 0);
        for (int k = 0; k < 40; k++)
            send_pixel(15'($urandom), $urandom_range(0, 2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_vlc_packer.md
RGB_VLC_PACKER -- requirements
Module: rgb_vlc_packer

Interface
REQ-001 The block SHALL have no parameters; channel width is fixed at 5 bits and channel count at 3.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pix_in  input  15  pixel {R[14:10], G[9:5], B[4:0]}.
REQ-005 pix_valid  input  1  pix_in holds a pixel to encode.
REQ-006 pix_ready  output  1  block can accept a pixel this cycle.
REQ-007 bit_out  output  1  current serial code bit.
REQ-008 bit_valid  output  1  bit_out is valid.
REQ-009 bit_ready  input  1  downstream accepts bit_out this cycle.
REQ-010 bit_last  output  1  bit_out is the final bit of the current pixel.

Function
REQ-011 Per channel value v[4:0]: the block SHALL compute the leading-one count c and mantissa m[3:0]: if v[4], c=4 and m=v[3:0]; else if v[3], c=3 and m={v[2:0],0}; else if v[2], c=2 and m={v[1:0],00}; else if v[1], c=1 and m={v[0],000}; else c=0 and m=0000.
REQ-012 Channel code SHALL be c[2:0] MSB-first, followed by the top c bits of m (m[3] first); no mantissa bits are emitted when c=0.
REQ-013 v=0 and v=1 SHALL both encode as 000; this loss is by design.
REQ-014 Pixel code SHALL be R code, then G code, then B code; length = 9+cR+cG+cB, range 9..21 bits.
REQ-015 Pixel transfer SHALL occur on a cycle with pix_valid=1 and pix_ready=1; pix_in SHALL be captured into an internal register on that edge.
REQ-016 FSM states: IDLE, CNT (emitting the 3 count bits), MANT (emitting c mantissa bits); the channel index SHALL run 0=R, 1=G, 2=B.
REQ-017 pix_ready SHALL be 1 only in IDLE; pixels are never accepted in CNT or MANT.
REQ-018 IDLE->CNT on pixel transfer, channel=R, bit index=2.
REQ-019 CNT: after the count-LSB transfer, go to MANT if c>0; else go to CNT of the next channel, or to IDLE if channel=B.
REQ-020 MANT: after the c-th mantissa-bit transfer, go to CNT of the next channel, or to IDLE if channel=B.
REQ-021 bit_valid SHALL be 1 exactly in CNT and MANT; the first bit SHALL be valid the cycle after pixel transfer.
REQ-022 A bit transfer occurs when bit_valid=1 and bit_ready=1; with bit_ready=1 continuously, one bit is transferred per cycle.
REQ-023 While bit_valid=1 and bit_ready=0, bit_out, bit_last and all state SHALL hold unchanged.
REQ-024 bit_last SHALL be 1 only with the final bit of channel B (count LSB if cB=0, else last mantissa bit).
REQ-025 After the last-bit transfer the FSM SHALL be in IDLE with pix_ready=1 the next cycle; minimum pixel period = code length + 1 cycles.
REQ-026 bit_out SHALL be driven from registered state only, with no combinational path from pix_in or bit_ready.

Reset
REQ-027 With rst=1 at a clock edge: state SHALL become IDLE; pix_ready=0 while rst=1; bit_valid=0, bit_last=0, bit_out=0; internal pixel register and indices cleared.
REQ-028 The first cycle after rst falls, pix_ready SHALL be 1.
REQ-029 rst SHALL take priority over all other inputs, including a mid-pixel stream or a simultaneous pix_valid; a partial pixel is discarded and not resumed.

Verification
REQ-030 pix_in=0x7FFF, bit_ready=1 -> 21 bits 1001111 1001111 1001111, bit_last on bit 21 only, pix_ready=1 one cycle later.
REQ-031 pix_in=0x0000, then 0x0021 (R=0,G=1,B=1) -> each emits 9 bits all 0 with bit_last on bit 9.
REQ-032 R=00101, G=00001, B=10000 -> 15 bits 01001 000 1000000, bit_last on bit 15.
REQ-033 Case REQ-030 with bit_ready pseudo-random (~50%) -> identical 21-bit sequence; bit_out/bit_last stable during every stall; no bits dropped or duplicated.
REQ-034 rst=1 for one cycle after 5th bit of REQ-030 pixel -> next cycle bit_valid=0, pix_ready=1; next pixel 0x0000 yields a clean 9-bit code.
REQ-035 pix_valid held high with changing pix_in during a pixel's emission -> pix_ready=0 and no capture until IDLE; the value present at the IDLE cycle is the one encoded.
